// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer, datapath
// steering decode, retired-instruction counter and sticky illegal-opcode flag.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        IRWr,
    output logic        PCWr,
    output logic [1:0]  Br,
    output logic [1:0]  RegIn,
    output logic        RegWr,
    output logic [1:0]  EXTOp,
    output logic        ALUsrc,
    output logic [2:0]  ALUOp,
    output logic        MemWr,
    output logic [1:0]  ToReg,
    output logic [2:0]  state,
    output logic [31:0] icount,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      st_q, st_d;
    logic [31:0] icount_q;
    logic        illegal_q;
    logic        irwr_c, pcwr_c, regwr_c, memwr_c;

    logic [5:0] op, fn;
    logic       is_r, is_addu, is_subu, is_jr, is_nop;
    logic       is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_ill;
    logic       active;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign fn          = instr[5:0];
    assign unused_bits = ^instr[25:6];

    assign is_r    = (op == 6'b000000);
    assign is_addu = is_r && (fn == 6'b100001);
    assign is_subu = is_r && (fn == 6'b100011);
    assign is_jr   = is_r && (fn == 6'b001000);
    assign is_nop  = is_r && (fn == 6'b000000);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign is_ill  = !(is_addu || is_subu || is_jr || is_nop || is_ori || is_lui ||
                       is_lw || is_sw || is_beq || is_j || is_jal);

    always_comb begin
        st_d    = S_FETCH;
        irwr_c  = 1'b0;
        pcwr_c  = 1'b0;
        regwr_c = 1'b0;
        memwr_c = 1'b0;
        case (st_q)
            S_FETCH: begin
                st_d   = S_DECODE;
                irwr_c = 1'b1;
            end
            S_DECODE: begin
                // Unsupported encodings retire here exactly like a nop.
                if (is_j || is_jr || is_nop || is_ill) begin
                    st_d   = S_FETCH;
                    pcwr_c = 1'b1;
                end else if (is_jal) begin
                    st_d = S_WB;
                end else begin
                    st_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    st_d   = S_FETCH;
                    pcwr_c = 1'b1;
                end else if (is_lw || is_sw) begin
                    st_d = S_MEM;
                end else begin
                    st_d = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    st_d    = S_FETCH;
                    pcwr_c  = 1'b1;
                    memwr_c = 1'b1;
                end else begin
                    st_d = S_WB;
                end
            end
            S_WB: begin
                st_d    = S_FETCH;
                pcwr_c  = 1'b1;
                regwr_c = 1'b1;
            end
            default: st_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= S_FETCH;
            icount_q  <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            st_q <= st_d;
            if (pcwr_c)
                icount_q <= icount_q + 32'd1;
            if (st_q == S_DECODE && is_ill)
                illegal_q <= 1'b1;
        end
    end

    // Strobes are gated by reset so nothing fires while the clear is held.
    assign IRWr  = irwr_c  & reset;
    assign PCWr  = pcwr_c  & reset;
    assign RegWr = regwr_c & reset;
    assign MemWr = memwr_c & reset;

    // Steering is decoded from instr in every state except FETCH.
    assign active = (st_q != S_FETCH);
    assign Br     = !active ? 2'b00 :
                    is_beq  ? 2'b01 :
                    (is_j || is_jal) ? 2'b10 :
                    is_jr   ? 2'b11 : 2'b00;
    assign RegIn  = !active ? 2'b00 :
                    (is_addu || is_subu) ? 2'b01 :
                    is_jal  ? 2'b10 : 2'b00;
    assign EXTOp  = !active ? 2'b00 :
                    (is_lw || is_sw) ? 2'b01 :
                    is_lui  ? 2'b10 : 2'b00;
    assign ALUsrc = active && (is_ori || is_lui || is_lw || is_sw);
    assign ALUOp  = !active ? 3'b000 :
                    (is_subu || is_beq) ? 3'b001 :
                    is_ori  ? 3'b010 : 3'b000;
    assign ToReg  = !active ? 2'b00 :
                    is_lw   ? 2'b01 :
                    is_jal  ? 2'b10 : 2'b00;

    assign state   = st_q;
    assign icount  = icount_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected outputs are queued when an
// instruction is issued and popped against the DUT on each falling edge.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        IRWr, PCWr, RegWr, MemWr, ALUsrc, illegal;
    logic [1:0]  Br, RegIn, EXTOp, ToReg;
    logic [2:0]  ALUOp, state;
    logic [31:0] icount;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr),
        .IRWr(IRWr), .PCWr(PCWr), .Br(Br), .RegIn(RegIn), .RegWr(RegWr),
        .EXTOp(EXTOp), .ALUsrc(ALUsrc), .ALUOp(ALUOp), .MemWr(MemWr),
        .ToReg(ToReg), .state(state), .icount(icount), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        irwr, pcwr, regwr, memwr;
        logic [1:0]  br, regin, extop;
        logic        alusrc;
        logic [2:0]  aluop;
        logic [1:0]  toreg;
        logic        ill;
        logic [31:0] icnt;
    } rec_t;

    rec_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl_icount = 32'd0;
    logic        mdl_ill = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string nm, input rec_t r);
        chk({nm, " state"},  32'(state),  32'(r.st));
        chk({nm, " IRWr"},   32'(IRWr),   32'(r.irwr));
        chk({nm, " PCWr"},   32'(PCWr),   32'(r.pcwr));
        chk({nm, " RegWr"},  32'(RegWr),  32'(r.regwr));
        chk({nm, " MemWr"},  32'(MemWr),  32'(r.memwr));
        chk({nm, " Br"},     32'(Br),     32'(r.br));
        chk({nm, " RegIn"},  32'(RegIn),  32'(r.regin));
        chk({nm, " EXTOp"},  32'(EXTOp),  32'(r.extop));
        chk({nm, " ALUsrc"}, 32'(ALUsrc), 32'(r.alusrc));
        chk({nm, " ALUOp"},  32'(ALUOp),  32'(r.aluop));
        chk({nm, " ToReg"},  32'(ToReg),  32'(r.toreg));
        chk({nm, " illegal"},32'(illegal),32'(r.ill));
        chk({nm, " icount"}, icount,      r.icnt);
    endtask

    // Holds reset low for three cycles, then releases it just after a rising edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst state",  32'(state),  32'd0);
            chk("rst IRWr",   32'(IRWr),   32'd0);
            chk("rst PCWr",   32'(PCWr),   32'd0);
            chk("rst icount", icount,      32'd0);
            chk("rst illegal",32'(illegal),32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        mdl_icount = 32'd0;
        mdl_ill = 1'b0;
    endtask

    // Issues one instruction starting in FETCH; abort_at >= 0 drops reset at
    // the start of that cycle index instead of completing.
    task automatic run_instr(input string nm, input logic [31:0] ins, input int abort_at);
        logic [5:0] op, fn;
        logic       addu, subu, jr, nop, ori, lui, lw, sw, beq, j, jal, ill;
        logic [2:0] path[$];
        rec_t       r;
        int         n;
        op = ins[31:26];
        fn = ins[5:0];
        addu = (op == 6'h00) && (fn == 6'h21);
        subu = (op == 6'h00) && (fn == 6'h23);
        jr   = (op == 6'h00) && (fn == 6'h08);
        nop  = (op == 6'h00) && (fn == 6'h00);
        ori  = (op == 6'h0D);
        lui  = (op == 6'h0F);
        lw   = (op == 6'h23);
        sw   = (op == 6'h2B);
        beq  = (op == 6'h04);
        j    = (op == 6'h02);
        jal  = (op == 6'h03);
        ill  = !(addu | subu | jr | nop | ori | lui | lw | sw | beq | j | jal);

        path.push_back(3'd0);
        path.push_back(3'd1);
        if (addu | subu | ori | lui) begin
            path.push_back(3'd2); path.push_back(3'd4);
        end else if (lw) begin
            path.push_back(3'd2); path.push_back(3'd3); path.push_back(3'd4);
        end else if (sw) begin
            path.push_back(3'd2); path.push_back(3'd3);
        end else if (beq) begin
            path.push_back(3'd2);
        end else if (jal) begin
            path.push_back(3'd4);
        end
        n = path.size();

        for (int c = 0; c < n; c++) begin
            r = '0;
            r.st   = path[c];
            r.icnt = mdl_icount;
            r.ill  = mdl_ill;
            if (c == 0) begin
                r.irwr = 1'b1;
            end else begin
                r.pcwr   = (c == n - 1);
                r.regwr  = (path[c] == 3'd4);
                r.memwr  = (path[c] == 3'd3) && sw;
                r.br     = beq ? 2'b01 : (j | jal) ? 2'b10 : jr ? 2'b11 : 2'b00;
                r.regin  = (addu | subu) ? 2'b01 : jal ? 2'b10 : 2'b00;
                r.extop  = (lw | sw) ? 2'b01 : lui ? 2'b10 : 2'b00;
                r.alusrc = ori | lui | lw | sw;
                r.aluop  = (subu | beq) ? 3'b001 : ori ? 3'b010 : 3'b000;
                r.toreg  = lw ? 2'b01 : jal ? 2'b10 : 2'b00;
            end
            sb.push_back(r);
            if (r.pcwr) mdl_icount = mdl_icount + 32'd1;
            if (path[c] == 3'd1 && ill) mdl_ill = 1'b1;
        end

        for (int c = 0; c < n; c++) begin
            if (c == abort_at) begin
                chk({nm, " pre-abort MemWr"}, 32'(MemWr), 32'(sw && path[c] == 3'd3));
                reset = 1'b0;
                #1;
                chk({nm, " abort state"}, 32'(state), 32'd0);
                chk({nm, " abort MemWr"}, 32'(MemWr), 32'd0);
                chk({nm, " abort PCWr"},  32'(PCWr),  32'd0);
                chk({nm, " abort IRWr"},  32'(IRWr),  32'd0);
                chk({nm, " abort icount"},icount,     32'd0);
                sb.delete();
                mdl_icount = 32'd0;
                mdl_ill = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            @(negedge clk);
            if (sb.size() == 0) begin
                chk({nm, " scoreboard empty"}, 32'd1, 32'd0);
            end else begin
                r = sb.pop_front();
                compare($sformatf("%s c%0d", nm, c), r);
            end
            @(posedge clk);
            #1;
            if (c == 0) instr = ins;
        end
    endtask

    initial begin
        do_reset();
        run_instr("addu", 32'h0022_1821, -1);
        run_instr("lw",   32'h8C22_0004, -1);
        run_instr("sw",   32'hAC22_0008, -1);
        run_instr("beq",  32'h1022_0003, -1);
        run_instr("jal",  32'h0C00_0040, -1);
        run_instr("ori",  32'h3423_00FF, -1);
        run_instr("lui",  32'h3C01_1234, -1);
        run_instr("subu", 32'h0022_1823, -1);
        run_instr("j",    32'h0800_0010, -1);
        run_instr("jr",   32'h03E0_0008, -1);
        run_instr("nop",  32'h0000_0000, -1);
        run_instr("ill",  32'hFC00_0000, -1);
        run_instr("addu2",32'h0022_1821, -1);
        run_instr("illfn",32'h0022_1825, -1);
        do_reset();
        run_instr("addu3",32'h0022_1821, -1);
        run_instr("swab", 32'hAC22_0008, 3);
        run_instr("addu4",32'h0022_1821, -1);

        force dut.icount_q = 32'hFFFF_FFFF;
        #1;
        release dut.icount_q;
        mdl_icount = 32'hFFFF_FFFF;
        run_instr("wrap", 32'h0000_0000, -1);
        run_instr("post", 32'h0000_0000, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
